imem_encoder: RTL and testbench
===============================

# imem_encoder

Sequential instruction encoder and loader for the LEGv8 single-cycle datapath. It accepts decoded instruction fields over a valid/ready stream, packs each into a 32-bit R/D/CB-format word whose opcode bits the main decoder recognises, and writes the words to consecutive instruction-memory addresses. It sits in front of the instruction memory and is used to load test programs before the core is released from reset.

## Interface
Parameters:
- ADDR_W, 6, instruction-memory word-address width (capacity 2^ADDR_W words)
- BASE_ADDR, 0, first word address written after start

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load session
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder accepts a bundle this cycle
- in_op  in  3  instruction kind: LDUR, STUR, CBZ, ADD, SUB, AND, ORR; other codes invalid
- in_rd  in  5  Rd (R-type) or Rt (D/CB-type)
- in_rn  in  5  Rn
- in_rm  in  5  Rm (R-type only)
- in_imm  in  19  D-type uses [8:0] as DT_address; CB-type uses [18:0] as CondBr_address
- in_last  in  1  marks final bundle of session
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- done  out  1  one-cycle pulse at end of session
- err  out  1  sticky: invalid op seen or memory overflow; cleared by start
- count  out  ADDR_W+1  words written in current/last session

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE: in_ready=0. start -> LOAD; clears err and count, loads address pointer with BASE_ADDR.
- LOAD: in_ready=1. Handshake = in_valid & in_ready.
- Encoding (opcode bits MSB first):
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: {op11, Rm, 6'b0, Rn, Rd}.
  - LDUR 11111000010, STUR 11111000000: {op11, imm[8:0], 2'b00, Rn, Rt}.
  - CBZ 10110100: {op8, imm[18:0], Rt}.
  - Unused imm bits ignored (truncate, no range check); in_rm ignored for D/CB.
- Valid handshake: encoded word and pointer captured into output register; pointer and count increment.
- Invalid in_op: err set, nothing written, pointer/count unchanged; bundle still consumed.
- Handshake with in_last -> FLUSH. Pointer wrap: when the write to address 2^ADDR_W-1 is accepted and in_last=0 -> err set, FLUSH.
- FLUSH: in_ready=0; final pending write issues -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- start outside IDLE ignored.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, busy=0, done=0, err=0, count=0, state IDLE.
- Reset mid-session: immediate abort, all outputs to reset values; partially loaded memory content is not restored.
- Latency: handshake in cycle N -> mem_we=1 in cycle N+1 with that word and address; one word per cycle sustained.
- mem_we asserted exactly one cycle per valid accepted bundle; never for invalid op.
- start in cycle N -> in_ready=1 from cycle N+1.
- Last handshake in cycle N -> write in N+1 (FLUSH), done in N+2, in_ready=1 again only after next start.
- busy=1 in LOAD, FLUSH, DONE.
- count updates with mem_we (visible the cycle after the write strobe rises), saturates at 2^ADDR_W.

## Structure
- Package legv8_pkg: instr kind enum (3-bit), opcode constants for ADD/SUB/AND/ORR/LDUR/STUR (11-bit) and CBZ (8-bit); shared with maindec benches.
- Sub-module instr_encode: combinational field-to-word packer plus valid-op flag; the FSM, pointer, and output register live in imem_encoder.

## Test plan
- start; ADD rd=3 rn=1 rm=2 with in_last -> mem_we one cycle at addr 0, wdata 0x8B020023; done two cycles after handshake; count=1.
- LDUR rt=2 rn=0 imm=8, then CBZ rt=5 imm=0x7FFFE last, back-to-back -> wdata 0xF8408002 at addr 0, 0xB4FFFFC5 at addr 1 in consecutive cycles.
- SUB/AND/ORR with valid toggled idle cycles -> one write per handshake, addresses contiguous, opcode fields 11001011000/10001010000/10101010000.
- in_op invalid between two ADDs -> err=1, only 2 writes at addr 0,1, count=2; next start clears err.
- ADDR_W=2, 5 bundles without in_last -> 4 writes (addr 0-3), err=1, in_ready drops after 4th handshake, done pulses.
- reset low during LOAD after 2 writes -> all outputs zero at once; start after release writes again from BASE_ADDR.

Source files
------------

// File: rtl/legv8_pkg.sv
// ---------------------------------------------------------------------------
// legv8_pkg
// Shared LEGv8 definitions: the 3-bit instruction-kind code carried on the
// encoder's in_op port, the opcode fields the main decoder recognises, and
// the loader FSM state type.
// ---------------------------------------------------------------------------
package legv8_pkg;

  // Instruction kind presented on in_op. Code 3'd7 is unused and is treated
  // as an invalid bundle.
  typedef enum logic [2:0] {
    OP_LDUR = 3'd0,
    OP_STUR = 3'd1,
    OP_CBZ  = 3'd2,
    OP_ADD  = 3'd3,
    OP_SUB  = 3'd4,
    OP_AND  = 3'd5,
    OP_ORR  = 3'd6,
    OP_INV  = 3'd7
  } instr_kind_e;

  // R-format and D-format opcodes occupy instruction bits [31:21].
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // CB-format opcode occupies instruction bits [31:24].
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  // Loader session states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

endpackage

// File: rtl/instr_encode.sv
// ---------------------------------------------------------------------------
// instr_encode
// Purely combinational packer: turns one decoded field bundle into a 32-bit
// LEGv8 R/D/CB-format word and flags whether the instruction kind is valid.
// Ports:
//   op    in  3   instruction kind (legv8_pkg::instr_kind_e code)
//   rd    in  5   Rd (R-format) or Rt (D/CB-format)
//   rn    in  5   Rn (ignored for CB-format)
//   rm    in  5   Rm (R-format only)
//   imm   in  19  D: [8:0] DT_address, CB: [18:0] CondBr_address
//   word  out 32  packed instruction (zero when op is invalid)
//   valid out 1   op is one of the seven supported kinds
// ---------------------------------------------------------------------------
module instr_encode
  import legv8_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [18:0] imm,
  output logic [31:0] word,
  output logic        valid
);

  // NOTE: every output of an always_comb block gets a default before the
  // case so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    word  = '0;
    valid = 1'b1;
    case (op)
      OP_ADD:  word = {OPC_ADD, rm, 6'b0, rn, rd};
      OP_SUB:  word = {OPC_SUB, rm, 6'b0, rn, rd};
      OP_AND:  word = {OPC_AND, rm, 6'b0, rn, rd};
      OP_ORR:  word = {OPC_ORR, rm, 6'b0, rn, rd};
      // D-format: op2 field is fixed at 2'b00; upper imm bits are dropped.
      OP_LDUR: word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
      OP_STUR: word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
      // CB-format has no Rn; rn and rm are don't-cares here.
      OP_CBZ:  word = {OPC_CBZ, imm, rd};
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_encoder.sv
// ---------------------------------------------------------------------------
// imem_encoder
// Sequential instruction loader. After a start pulse it accepts field
// bundles on a valid/ready stream, encodes each one and writes the words to
// consecutive instruction-memory addresses through a registered write port.
// Ports:
//   clk        in  1         rising-edge clock
//   reset      in  1         asynchronous active-low reset
//   start      in  1         begins a load session (honoured only when idle)
//   in_valid   in  1         field bundle valid
//   in_ready   out 1         bundle accepted this cycle when in_valid is high
//   in_op      in  3         instruction kind
//   in_rd      in  5         Rd / Rt
//   in_rn      in  5         Rn
//   in_rm      in  5         Rm
//   in_imm     in  19        immediate field source
//   in_last    in  1         final bundle of the session
//   mem_we     out 1         instruction-memory write strobe
//   mem_addr   out ADDR_W    write word address
//   mem_wdata  out 32        encoded instruction
//   busy       out 1         session in progress
//   done       out 1         one-cycle end-of-session pulse
//   err        out 1         sticky invalid-op / overflow flag, cleared by start
//   count      out ADDR_W+1  words written in current or last session
// ---------------------------------------------------------------------------
module imem_encoder
  import legv8_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_MAX = {1'b1, {ADDR_W{1'b0}}};

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic [31:0]       enc_word;
  logic              enc_valid;
  logic              hs;

  instr_encode u_encode (
    .op    (in_op),
    .rd    (in_rd),
    .rn    (in_rn),
    .rm    (in_rm),
    .imm   (in_imm),
    .word  (enc_word),
    .valid (enc_valid)
  );

  assign in_ready = (state_q == ST_LOAD);
  assign hs       = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;
    count_d     = count_q;

    // count trails the write strobe by one cycle and never passes capacity.
    if (mem_we_q && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = BASE;
          err_d   = 1'b0;
          count_d = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          if (enc_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = enc_word;
            ptr_d       = ptr_q + 1'b1;
            // Writing the top word with more bundles still to come would
            // wrap onto the start of the program: stop the session instead.
            if ((ptr_q == PTR_MAX) && !in_last) begin
              err_d   = 1'b1;
              state_d = ST_FLUSH;
            end
          end else begin
            // Invalid kinds are consumed but never written.
            err_d = 1'b1;
          end
          if (in_last) begin
            state_d = ST_FLUSH;
          end
        end
      end
      // The last accepted word is on the write port during this cycle.
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= BASE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;
  assign count     = count_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_imem_encoder.sv
// ---------------------------------------------------------------------------
// tb_imem_encoder
// Self-checking bench for imem_encoder: directed table of encodings, timing
// sequences for the session corner cases, a small-memory instance for the
// overflow rule, and randomized sessions against a reference model.
// ---------------------------------------------------------------------------
module tb_imem_encoder;
  import legv8_pkg::*;

  localparam int AW  = 6;
  localparam int AW2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b0;
  logic          start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic          start2 = 1'b0, in_valid2 = 1'b0;
  logic [2:0]    in_op = '0;
  logic [4:0]    in_rd = '0, in_rn = '0, in_rm = '0;
  logic [18:0]   in_imm = '0;

  logic          in_ready, mem_we, busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;

  logic           in_ready2, mem_we2, busy2, done2, err2;
  logic [AW2-1:0] mem_addr2;
  logic [31:0]    mem_wdata2;
  logic [AW2:0]   count2;

  imem_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn),
    .in_rm(in_rm), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .count(count)
  );

  imem_encoder #(.ADDR_W(AW2), .BASE_ADDR(0)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_op(in_op), .in_rd(in_rd), .in_rn(in_rn),
    .in_rm(in_rm), .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .busy(busy2), .done(done2),
    .err(err2), .count(count2)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor used by the randomized sessions.
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      obs_addr.push_back(int'(mem_addr));
      obs_data.push_back(mem_wdata);
    end
  end

  // Reference encoding built from the field layout with plain arithmetic.
  function automatic logic [31:0] ref_enc(input int op, input longint rd, input longint rn,
                                          input longint rm, input longint imm);
    longint w;
    case (op)
      3:       w = 64'h458 * 2**21 + rm * 2**16 + rn * 2**5 + rd;           // ADD 10001011000
      4:       w = 64'h658 * 2**21 + rm * 2**16 + rn * 2**5 + rd;           // SUB 11001011000
      5:       w = 64'h450 * 2**21 + rm * 2**16 + rn * 2**5 + rd;           // AND 10001010000
      6:       w = 64'h550 * 2**21 + rm * 2**16 + rn * 2**5 + rd;           // ORR 10101010000
      0:       w = 64'h7C2 * 2**21 + (imm % 512) * 2**12 + rn * 2**5 + rd;  // LDUR 11111000010
      1:       w = 64'h7C0 * 2**21 + (imm % 512) * 2**12 + rn * 2**5 + rd;  // STUR 11111000000
      2:       w = 64'hB4 * 2**24 + (imm % 2**19) * 2**5 + rd;              // CBZ 10110100
      default: w = 0;
    endcase
    return 32'(w);
  endfunction

  task automatic drive(input logic [2:0] op, input int rd, input int rn, input int rm,
                       input int imm, input logic last);
    in_op   = op;
    in_rd   = 5'(rd);
    in_rn   = 5'(rn);
    in_rm   = 5'(rm);
    in_imm  = 19'(imm);
    in_last = last;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
  endtask

  // One randomized session; the model decides which writes must appear.
  task automatic rand_session(input int nb);
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          ptr = 0;
    bit          exp_err = 1'b0;
    obs_addr.delete();
    obs_data.delete();
    pulse_start();
    for (int i = 0; i < nb; i++) begin
      int op, rd, rn, rm, imm;
      bit last;
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      op   = int'($urandom_range(0, 7));
      rd   = int'($urandom_range(0, 31));
      rn   = int'($urandom_range(0, 31));
      rm   = int'($urandom_range(0, 31));
      imm  = int'($urandom_range(0, 19'h7FFFF));
      last = (i == nb - 1);
      check("rand_ready", 64'(in_ready), 64'd1);
      drive(3'(op), rd, rn, rm, imm, last);
      in_valid = 1'b1;
      @(negedge clk);
      if (op <= 6) begin
        exp_addr.push_back(ptr);
        exp_data.push_back(ref_enc(op, rd, rn, rm, imm));
        ptr++;
      end else begin
        exp_err = 1'b1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_done("rand");
    check("rand_err", 64'(err), 64'(exp_err));
    check("rand_count", 64'(count), 64'(exp_addr.size()));
    check("rand_nwrites", 64'(obs_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check("rand_addr", 64'(obs_addr[i]), 64'(exp_addr[i]));
      check("rand_wdata", 64'(obs_data[i]), 64'(exp_data[i]));
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    int          rd, rn, rm, imm;
    logic [31:0] word;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{OP_ADD,   3,  1,  2, 0,        32'h8B020023};
    tbl[1] = '{OP_LDUR,  2,  0,  0, 8,        32'hF8408002};
    tbl[2] = '{OP_CBZ,   5,  0,  0, 'h7FFFE,  32'hB4FFFFC5};
    tbl[3] = '{OP_SUB,   4,  5,  6, 0,        32'hCB0600A4};
    tbl[4] = '{OP_AND,   7,  8,  9, 0,        32'h8A090107};
    tbl[5] = '{OP_ORR,  31, 31, 31, 0,        32'hAA1F03FF};
    tbl[6] = '{OP_STUR,  1,  2, 31, 'h7FFFF,  32'hF81FF041};
    tbl[7] = '{OP_LDUR, 31, 31,  7, 0,        32'hF84003FF};
    tbl[8] = '{OP_CBZ,   0, 17, 31, 1,        32'hB4000020};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(in_ready), 64'd0);

    // Single ADD with last: exact cycle-by-cycle timing.
    pulse_start();
    check("t1_ready_after_start", 64'(in_ready), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    drive(OP_ADD, 3, 1, 2, 0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t1_we", 64'(mem_we), 64'd1);
    check("t1_addr", 64'(mem_addr), 64'd0);
    check("t1_wdata", 64'(mem_wdata), 64'h8B020023);
    check("t1_ready_flush", 64'(in_ready), 64'd0);
    check("t1_done_early", 64'(done), 64'd0);
    @(negedge clk);
    check("t1_done", 64'(done), 64'd1);
    check("t1_we_once", 64'(mem_we), 64'd0);
    check("t1_count", 64'(count), 64'd1);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_ready_end", 64'(in_ready), 64'd0);

    // Table of encodings, back-to-back: one write per cycle, contiguous.
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm, i == 8);
      in_valid = 1'b1;
      @(negedge clk);
      check("tbl_we", 64'(mem_we), 64'd1);
      check("tbl_addr", 64'(mem_addr), 64'(i));
      check("tbl_wdata", 64'(mem_wdata), 64'(tbl[i].word));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    check("tbl_done", 64'(done), 64'd1);
    check("tbl_count", 64'(count), 64'd9);
    check("tbl_err", 64'(err), 64'd0);

    // Invalid op between two ADDs.
    pulse_start();
    drive(OP_ADD, 1, 2, 3, 0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    check("inv_we0", 64'(mem_we), 64'd1);
    check("inv_addr0", 64'(mem_addr), 64'd0);
    drive(OP_INV, 9, 9, 9, 0, 1'b0);
    @(negedge clk);
    check("inv_no_we", 64'(mem_we), 64'd0);
    check("inv_err", 64'(err), 64'd1);
    drive(OP_ADD, 4, 5, 6, 0, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("inv_we1", 64'(mem_we), 64'd1);
    check("inv_addr1", 64'(mem_addr), 64'd1);
    check("inv_wdata1", 64'(mem_wdata), 64'(ref_enc(3, 4, 5, 6, 0)));
    @(negedge clk);
    check("inv_done", 64'(done), 64'd1);
    check("inv_count", 64'(count), 64'd2);
    check("inv_err_sticky", 64'(err), 64'd1);
    @(negedge clk);
    check("inv_err_idle", 64'(err), 64'd1);
    pulse_start();
    check("inv_err_cleared", 64'(err), 64'd0);
    check("inv_count_cleared", 64'(count), 64'd0);
    drive(OP_ORR, 1, 1, 1, 0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_done("inv_close");

    // Overflow on the 4-word instance.
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("ovf_ready", 64'(in_ready2), 64'(i < 4));
      drive(OP_ADD, i + 1, 2, 3, 0, 1'b0);
      in_valid2 = 1'b1;
      @(negedge clk);
      check("ovf_we", 64'(mem_we2), 64'(i < 4));
      if (i < 4) begin
        check("ovf_addr", 64'(mem_addr2), 64'(i));
        check("ovf_wdata", 64'(mem_wdata2), 64'(ref_enc(3, i + 1, 2, 3, 0)));
      end
    end
    in_valid2 = 1'b0;
    check("ovf_done", 64'(done2), 64'd1);
    check("ovf_err", 64'(err2), 64'd1);
    check("ovf_count", 64'(count2), 64'd4);
    @(negedge clk);
    check("ovf_idle_ready", 64'(in_ready2), 64'd0);
    check("ovf_idle_busy", 64'(busy2), 64'd0);

    // Reset in the middle of a session.
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      drive(OP_ADD, i, i, i, 0, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
    end
    check("mid_we_before", 64'(mem_we), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_in_ready", 64'(in_ready), 64'd0);
    check("mid_mem_we", 64'(mem_we), 64'd0);
    check("mid_mem_addr", 64'(mem_addr), 64'd0);
    check("mid_mem_wdata", 64'(mem_wdata), 64'd0);
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_err", 64'(err), 64'd0);
    check("mid_count", 64'(count), 64'd0);
    in_valid = 1'b0;
    @(negedge clk) reset = 1'b1;
    pulse_start();
    drive(OP_SUB, 7, 6, 5, 0, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("mid_restart_we", 64'(mem_we), 64'd1);
    check("mid_restart_addr", 64'(mem_addr), 64'd0);
    wait_done("mid_restart");
    check("mid_restart_count", 64'(count), 64'd1);

    // Randomized sessions.
    for (int s = 0; s < 25; s++) begin
      rand_session(int'($urandom_range(1, 12)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
